add7_host_driver: RTL and testbench

//  Host-side caller for the synthesized 7-operand adder kernel. Collects operands from a

---
 rtl/add7_pkg.sv | 16 +
 rtl/add7_host_driver.sv | 131 +++++++++++++
 tb/tb_add7_host_driver.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/add7_pkg.sv
// Shared definitions for the 7-operand adder host driver.
package add7_pkg;

  // Call sequencer states: gather operands, pulse the kernel, wait for done, hand back result.
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } add7_state_e;

  localparam int ADD7_N_ARGS     = 7;
  localparam int ADD7_WIDTH      = 32;
  localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/add7_host_driver.sv
// Host-side caller for the 7-operand adder kernel: streams operands in, pulses the
// kernel once, waits (bounded) for its done level and streams the result back out.
module add7_host_driver
  import add7_pkg::*;
#(
  parameter int WIDTH   = ADD7_WIDTH,
  parameter int N_ARGS  = ADD7_N_ARGS,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [WIDTH-1:0]        s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [WIDTH-1:0]        m_data,
  output logic                    m_error,
  output logic                    busy,
  output logic                    acc_r_enable,
  output logic [N_ARGS*WIDTH-1:0] acc_init,
  input  logic                    acc_w_enable,
  input  logic [WIDTH-1:0]        acc_result
);

  localparam int CNT_W = (N_ARGS > 1) ? $clog2(N_ARGS) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ARGS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  add7_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             m_error_q, m_error_d;
  logic             accept;

  assign accept = s_valid && s_ready;

  // State, operand counter, wait timer and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      cnt_q     <= '0;
      tmo_q     <= '0;
      m_data_q  <= '0;
      m_error_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      m_data_q  <= m_data_d;
      m_error_q <= m_error_d;
    end
  end

  // Operand slots: slot k is written by the k-th accepted operand of a call and then
  // held untouched until the next call, so the kernel sees stable inputs throughout.
  for (genvar gi = 0; gi < N_ARGS; gi++) begin : g_slot
    logic [WIDTH-1:0] slot_q;

    // Capture operand number gi of the current call.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_q <= '0;
      end else if (accept && (cnt_q == CNT_W'(gi))) begin
        slot_q <= s_data;
      end
    end

    assign acc_init[gi*WIDTH +: WIDTH] = slot_q;
  end

  // Next-state logic. acc_w_enable is only looked at in WAIT: before the start pulse the
  // kernel's done level still belongs to the previous call.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    m_data_d  = m_data_q;
    m_error_d = m_error_q;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ISSUE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Done is checked first so a done arriving on the last wait cycle still wins.
        if (acc_w_enable) begin
          m_data_d  = acc_result;
          m_error_d = 1'b0;
          state_d   = RESPOND;
        end else if (tmo_q == TMO_LAST) begin
          m_data_d  = '0;
          m_error_d = 1'b1;
          state_d   = RESPOND;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      RESPOND: begin
        if (m_ready) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Stream and kernel handshake outputs decoded from the current state.
  always_comb begin
    s_ready      = (state_q == COLLECT) && rst_n;
    m_valid      = (state_q == RESPOND);
    acc_r_enable = (state_q == ISSUE);
    busy         = !((state_q == COLLECT) && (cnt_q == '0));
  end

  assign m_data  = m_data_q;
  assign m_error = m_error_q;

endmodule

// File: tb/tb_add7_host_driver.sv
// Self-checking bench for add7_host_driver with a behavioural kernel model.
module tb_add7_host_driver;
  import add7_pkg::*;

  localparam int W   = ADD7_WIDTH;
  localparam int N   = ADD7_N_ARGS;
  localparam int TMO = DEFAULT_TIMEOUT;

  typedef logic [N-1:0][W-1:0] ops_t;

  typedef struct packed {
    ops_t        ops;
    int          gap;
    int          hold;
    int          k;
    bit          never;
    logic [31:0] exp_data;
    bit          exp_err;
    int          exp_wait;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           s_valid;
  logic           s_ready;
  logic [W-1:0]   s_data;
  logic           m_valid;
  logic           m_ready;
  logic [W-1:0]   m_data;
  logic           m_error;
  logic           busy;
  logic           acc_r_enable;
  logic [N*W-1:0] acc_init;
  logic           acc_w_enable = 1'b0;
  logic [W-1:0]   acc_result   = '0;

  always #5 clk = ~clk;

  add7_host_driver #(.WIDTH(W), .N_ARGS(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_error(m_error),
    .busy(busy), .acc_r_enable(acc_r_enable), .acc_init(acc_init),
    .acc_w_enable(acc_w_enable), .acc_result(acc_result)
  );

  // ---------------- kernel model ----------------
  int             cyc = 0;
  int             k_delay = 6;
  bit             k_never = 1'b0;
  bit             k_stale_req = 1'b0;
  logic [W-1:0]   k_stale_val = '0;
  int             k_rem = 0;
  logic [W-1:0]   k_sum = '0;
  int             r_count = 0;
  int             r_edge = 0;
  logic [N*W-1:0] k_init = '0;
  int             last_acc_edge = 0;

  function automatic logic [W-1:0] kernel_add(input logic [N*W-1:0] v);
    logic [W-1:0] s;
    s = '0;
    for (int j = 0; j < N; j++) s = s + v[j*W +: W];
    return s;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (acc_r_enable) begin
      r_count      <= r_count + 1;
      r_edge       <= cyc;
      k_init       <= acc_init;
      k_sum        <= kernel_add(acc_init);
      k_rem        <= k_never ? 0 : k_delay;
      acc_w_enable <= 1'b0;
      acc_result   <= 32'hDEAD_BEEF;
    end else if (k_stale_req) begin
      acc_w_enable <= 1'b1;
      acc_result   <= k_stale_val;
    end else if (k_rem > 0) begin
      k_rem <= k_rem - 1;
      if (k_rem == 1) begin
        acc_w_enable <= 1'b1;
        acc_result   <= k_sum;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the driver returns the wrapped sum if the kernel finishes within
  // TIMEOUT wait cycles (done visible K+1 edges after the start edge), else 0 with error.
  function automatic void model(input ops_t ops, input int k, input bit never,
                                output logic [31:0] d, output bit e, output int wt);
    longint unsigned s;
    s = 0;
    for (int j = 0; j < N; j++) s += ops[j];
    if (never || (k + 1 > TMO)) begin
      d = 0; e = 1'b1; wt = TMO;
    end else begin
      d = s[31:0]; e = 1'b0; wt = k + 1;
    end
  endfunction

  function automatic ops_t seq(input logic [31:0] base, input logic [31:0] step);
    ops_t o;
    for (int j = 0; j < N; j++) o[j] = base + step * j;
    return o;
  endfunction

  task automatic send_ops(input ops_t ops, input int gap_max, input int count);
    for (int i = 0; i < count; i++) begin
      int g;
      int waited;
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      s_valid = 1'b0;
      repeat (g) @(negedge clk);
      s_valid = 1'b1;
      s_data  = ops[i];
      waited  = 0;
      while (!s_ready && waited < 300) begin
        @(negedge clk);
        waited++;
      end
      if (!s_ready) begin
        check("s_ready_wait", 64'(s_ready), 64'd1);
        s_valid = 1'b0;
        return;
      end
      last_acc_edge = cyc;
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic recv_check(input string tag, input int hold, input logic [31:0] exp_d,
                            input bit exp_e, input int exp_wait, input int r_before,
                            input ops_t ops);
    int          waited;
    int          mv_edge;
    bit          stable;
    logic [31:0] first;
    waited  = 0;
    stable  = 1'b1;
    m_ready = (hold == 0);
    while (!m_valid && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!m_valid) begin
      check({tag, "_mvalid_timeout"}, 64'(m_valid), 64'd1);
      m_ready = 1'b1;
      return;
    end
    mv_edge = cyc - 1;
    first   = m_data;
    for (int h = 0; h < hold; h++) begin
      if (m_data !== first || s_ready !== 1'b0 || m_valid !== 1'b1 || busy !== 1'b1)
        stable = 1'b0;
      @(negedge clk);
    end
    $display("[TB] call %s: data=0x%08h err=%0d wait=%0d", tag, m_data, m_error,
             mv_edge - r_edge);
    check({tag, "_stable"}, 64'(stable), 64'd1);
    check({tag, "_data"}, 64'(m_data), 64'(exp_d));
    check({tag, "_err"}, 64'(m_error), 64'(exp_e));
    check({tag, "_wait"}, 64'(mv_edge - r_edge), 64'(exp_wait));
    check({tag, "_latency"}, 64'(mv_edge - last_acc_edge), 64'(exp_wait + 1));
    check({tag, "_pulses"}, 64'(r_count - r_before), 64'd1);
    check({tag, "_init_held"}, 64'(acc_init == k_init), 64'd1);
    for (int j = 0; j < N; j++)
      check($sformatf("%s_slot%0d", tag, j), 64'(k_init[j*W +: W]), 64'(ops[j]));
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check({tag, "_drain"}, 64'(m_valid), 64'd0);
  endtask

  task automatic run_call(input string tag, input vec_t v);
    int r_before;
    k_delay  = v.k;
    k_never  = v.never;
    r_before = r_count;
    send_ops(v.ops, v.gap, N);
    recv_check(tag, v.hold, v.exp_data, v.exp_err, v.exp_wait, r_before, v.ops);
  endtask

  task automatic chk_reset_outs(input string tag);
    check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    check({tag, "_m_data"}, 64'(m_data), 64'd0);
    check({tag, "_m_error"}, 64'(m_error), 64'd0);
    check({tag, "_r_enable"}, 64'(acc_r_enable), 64'd0);
    check({tag, "_init_zero"}, 64'(acc_init == '0), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  vec_t vecs [8];
  vec_t rv;
  int   r_mid;

  initial begin
    // Directed table: expected values are hand-computed.
    vecs[0] = '{ops: seq(1, 1),     gap: 0, hold: 0, k: 6,  never: 0,
                exp_data: 28,  exp_err: 0, exp_wait: 7};
    vecs[1] = '{ops: seq(10, 10),   gap: 2, hold: 5, k: 4,  never: 0,
                exp_data: 280, exp_err: 0, exp_wait: 5};
    vecs[2] = '{ops: seq(1, 1),     gap: 0, hold: 0, k: 3,  never: 0,
                exp_data: 28,  exp_err: 0, exp_wait: 4};
    vecs[3] = '{ops: seq(11, 1),    gap: 0, hold: 1, k: 6,  never: 1,
                exp_data: 0,   exp_err: 1, exp_wait: 64};
    vecs[4] = '{ops: seq(3, 1),     gap: 1, hold: 0, k: 5,  never: 0,
                exp_data: 42,  exp_err: 0, exp_wait: 6};
    vecs[5] = '{ops: seq(100, 1),   gap: 0, hold: 0, k: 63, never: 0,
                exp_data: 721, exp_err: 0, exp_wait: 64};
    vecs[6] = '{ops: seq(1, 1),     gap: 0, hold: 2, k: 64, never: 0,
                exp_data: 0,   exp_err: 1, exp_wait: 64};
    vecs[7] = '{ops: seq(32'hFFFF_FFFF, 0), gap: 0, hold: 0, k: 2, never: 0,
                exp_data: 32'hFFFF_FFF9, exp_err: 0, exp_wait: 3};

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs("por");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_s_ready", 64'(s_ready), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 8; i++) run_call($sformatf("vec%0d", i), vecs[i]);

    // Stale done level held before a call must not end the new call early.
    k_stale_val = 32'd999;
    k_stale_req = 1'b1;
    @(negedge clk);
    k_stale_req = 1'b0;
    repeat (3) @(negedge clk);
    check("stale_idle_m_valid", 64'(m_valid), 64'd0);
    run_call("stale", '{ops: seq(1, 1), gap: 0, hold: 0, k: 6, never: 0,
                        exp_data: 28, exp_err: 0, exp_wait: 7});

    // Reset after four operands.
    send_ops(seq(50, 1), 0, 4);
    check("part_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_collect");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_call("after_rst1", '{ops: seq(1, 1), gap: 0, hold: 0, k: 6, never: 0,
                             exp_data: 28, exp_err: 0, exp_wait: 7});

    // Reset while waiting on the kernel; the kernel finishes later into an idle driver.
    k_delay = 20;
    k_never = 1'b0;
    send_ops(seq(9, 0), 0, N);
    repeat (3) @(negedge clk);
    r_mid = r_count;
    check("wait_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_wait");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("rst_no_repulse", 64'(r_count - r_mid), 64'd0);
    check("rst_idle_m_valid", 64'(m_valid), 64'd0);
    run_call("after_rst2", '{ops: seq(1, 1), gap: 0, hold: 0, k: 6, never: 0,
                             exp_data: 28, exp_err: 0, exp_wait: 7});

    // Randomized calls checked against the reference model.
    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < N; j++)
        rv.ops[j] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 1000);
      rv.gap   = $urandom_range(0, 2);
      rv.hold  = $urandom_range(0, 3);
      rv.k     = $urandom_range(1, 70);
      rv.never = ($urandom_range(0, 7) == 0);
      model(rv.ops, rv.k, rv.never, rv.exp_data, rv.exp_err, rv.exp_wait);
      run_call($sformatf("rnd%0d", i), rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
